// File: rtl/vga_palette_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_palette_pkg
//  Brief    : Shared types, CGA default palette and channel widening helper.
//  Revision : 1.0
// ============================================================================
package vga_palette_pkg;

    typedef enum logic [1:0] {
        PH_R = 2'd0,
        PH_G = 2'd1,
        PH_B = 2'd2
    } phase_t;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // {R,G,B} at 6 bits per channel, element 15 first
    localparam logic [15:0][17:0] CGA_PALETTE = {
        18'h3FFFF, 18'h3FFD5, 18'h3F57F, 18'h3F555,
        18'h15FFF, 18'h15FD5, 18'h1557F, 18'h15555,
        18'h2AAAA, 18'h2A540, 18'h2A02A, 18'h2A000,
        18'h00AAA, 18'h00A80, 18'h0002A, 18'h00000
    };

    // Left-justified channel widened by cyclic MSB replication (up to 16 bits)
    function automatic logic [15:0] widen(input logic [15:0] ch, input int ch_w, input int out_w);
        logic [15:0] res;
        res = '0;
        for (int i = 0; i < out_w; i++) begin
            res[4'(out_w - 1 - i)] = ch[4'(ch_w - 1 - (i % ch_w))];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_palette_ram.sv
`default_nettype none
// ============================================================================
//  Module   : vga_palette_ram
//  Brief    : Simple dual-port palette RAM, registered reads, no reset.
//  Revision : 1.0
// ============================================================================
module vga_palette_ram #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 18
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] i_a_addr,
    output logic [DATA_W-1:0] o_a_rdata,
    input  logic              i_b_we,
    input  logic              i_b_re,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic [DATA_W-1:0] i_b_wdata,
    output logic [DATA_W-1:0] o_b_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_a_rdata;
    logic [DATA_W-1:0] r_b_rdata;

    always_ff @(posedge clk) begin
        r_a_rdata <= r_mem[i_a_addr];
    end

    // Write has priority over a port-B fetch; the fetch holds its last data
    always_ff @(posedge clk) begin
        if (i_b_we) begin
            r_mem[i_b_addr] <= i_b_wdata;
        end else if (i_b_re) begin
            r_b_rdata <= r_mem[i_b_addr];
        end
    end

    assign o_a_rdata = r_a_rdata;
    assign o_b_rdata = r_b_rdata;

endmodule
`default_nettype wire

// File: rtl/vga_palette_dac.sv
`default_nettype none
// ============================================================================
//  Module   : vga_palette_dac
//  Brief    : Programmable palette lookup with VGA-DAC style host sequencers.
//  Revision : 1.0
// ============================================================================
module vga_palette_dac
    import vga_palette_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int CH_W  = 6,
    parameter int OUT_W = 7
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [IDX_W-1:0] video,
    input  logic             blank,
    output logic [OUT_W-1:0] red,
    output logic [OUT_W-1:0] green,
    output logic [OUT_W-1:0] blue,
    output logic             init_busy,
    input  logic [IDX_W-1:0] pel_mask,
    input  logic             cpu_wr_idx,
    input  logic             cpu_wr_data,
    input  logic             cpu_rd_idx,
    input  logic             cpu_rd_data,
    input  logic [7:0]       cpu_din,
    output logic [CH_W-1:0]  cpu_rdata
);

    localparam int DW = 3 * CH_W;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_init_we;
    logic             w_run;
    logic [IDX_W-1:0] r_init_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_INIT;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_INIT && r_init_cnt == '1) w_state_nxt = ST_RUN;
    end

    always_comb begin
        w_init_we = 1'b0;
        w_run     = 1'b0;
        case (r_state)
            ST_INIT: w_init_we = 1'b1;
            ST_RUN:  w_run     = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       r_init_cnt <= '0;
        else if (w_init_we) r_init_cnt <= r_init_cnt + IDX_W'(1);
    end

    assign init_busy = w_init_we;

    // Entries below 16 take the CGA colours, everything above is black
    logic [IDX_W+3:0] w_init_ext;
    logic             w_init_cga;
    logic [17:0]      w_cga_rgb;
    logic [DW-1:0]    w_init_data;

    assign w_init_ext = {4'b0, r_init_cnt};
    assign w_init_cga = (w_init_ext < (IDX_W + 4)'(16));
    assign w_cga_rgb  = CGA_PALETTE[w_init_ext[3:0]];

    for (genvar c = 0; c < 3; c++) begin : g_init_ch
        logic [CH_W-1:0] w_scaled;
        if (CH_W == 6) begin : g_same
            assign w_scaled = w_cga_rgb[6*c +: 6];
        end else if (CH_W > 6) begin : g_wide
            assign w_scaled = {w_cga_rgb[6*c +: 6], {(CH_W-6){1'b0}}};
        end else begin : g_narrow
            assign w_scaled = w_cga_rgb[6*c+5 -: CH_W];
        end
        assign w_init_data[CH_W*c +: CH_W] = w_init_cga ? w_scaled : '0;
    end

    // Write sequencer
    phase_t           r_wr_ph;
    logic [IDX_W-1:0] r_wr_idx;
    logic [CH_W-1:0]  r_wr_r;
    logic [CH_W-1:0]  r_wr_g;
    logic [CH_W-1:0]  w_din_ch;
    logic             w_commit;
    logic             w_unused_din;

    assign w_din_ch     = cpu_din[CH_W-1:0];
    assign w_unused_din = ^cpu_din;
    assign w_commit     = w_run & cpu_wr_data & ~cpu_wr_idx & (r_wr_ph == PH_B);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ph  <= PH_R;
            r_wr_idx <= '0;
            r_wr_r   <= '0;
            r_wr_g   <= '0;
        end else if (w_run) begin
            if (cpu_wr_idx) begin
                r_wr_idx <= cpu_din[IDX_W-1:0];
                r_wr_ph  <= PH_R;
            end else if (cpu_wr_data) begin
                case (r_wr_ph)
                    PH_R: begin
                        r_wr_r  <= w_din_ch;
                        r_wr_ph <= PH_G;
                    end
                    PH_G: begin
                        r_wr_g  <= w_din_ch;
                        r_wr_ph <= PH_B;
                    end
                    default: begin
                        r_wr_idx <= r_wr_idx + IDX_W'(1);
                        r_wr_ph  <= PH_R;
                    end
                endcase
            end
        end
    end

    // Read sequencer; a fetch stays pending until port B is free of writes
    phase_t           r_rd_ph;
    logic [IDX_W-1:0] r_rd_idx;
    logic             r_fetch_pend;
    logic             r_fetch_done;
    logic [DW-1:0]    r_rd_latch;
    logic             w_b_we;
    logic             w_fetch;
    logic [IDX_W-1:0] w_b_addr;
    logic [DW-1:0]    w_b_wdata;
    logic [DW-1:0]    w_b_rdata;
    logic [DW-1:0]    w_a_rdata;

    assign w_b_we    = w_init_we | w_commit;
    assign w_fetch   = r_fetch_pend & ~w_b_we;
    assign w_b_addr  = w_init_we ? r_init_cnt : (w_commit ? r_wr_idx : r_rd_idx);
    assign w_b_wdata = w_init_we ? w_init_data : {r_wr_r, r_wr_g, w_din_ch};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ph      <= PH_R;
            r_rd_idx     <= '0;
            r_fetch_pend <= 1'b0;
            r_fetch_done <= 1'b0;
            r_rd_latch   <= '0;
        end else begin
            r_fetch_done <= w_fetch;
            if (r_fetch_done) r_rd_latch <= w_b_rdata;
            if (w_fetch) r_fetch_pend <= 1'b0;
            if (w_run) begin
                if (cpu_rd_idx) begin
                    r_rd_idx     <= cpu_din[IDX_W-1:0];
                    r_rd_ph      <= PH_R;
                    r_fetch_pend <= 1'b1;
                end else if (cpu_rd_data) begin
                    case (r_rd_ph)
                        PH_R: r_rd_ph <= PH_G;
                        PH_G: r_rd_ph <= PH_B;
                        default: begin
                            r_rd_idx     <= r_rd_idx + IDX_W'(1);
                            r_rd_ph      <= PH_R;
                            r_fetch_pend <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    always_comb begin
        cpu_rdata = r_rd_latch[2*CH_W +: CH_W];
        case (r_rd_ph)
            PH_G:    cpu_rdata = r_rd_latch[CH_W +: CH_W];
            PH_B:    cpu_rdata = r_rd_latch[0 +: CH_W];
            default: ;
        endcase
    end

    vga_palette_ram #(
        .ADDR_W (IDX_W),
        .DATA_W (DW)
    ) u_ram (
        .clk       (clk),
        .i_a_addr  (video & pel_mask),
        .o_a_rdata (w_a_rdata),
        .i_b_we    (w_b_we),
        .i_b_re    (w_fetch),
        .i_b_addr  (w_b_addr),
        .i_b_wdata (w_b_wdata),
        .o_b_rdata (w_b_rdata)
    );

    // Video path: blank and run status travel alongside the RAM read
    logic             r_vid_ok;
    logic [OUT_W-1:0] w_red_wide;
    logic [OUT_W-1:0] w_grn_wide;
    logic [OUT_W-1:0] w_blu_wide;

    assign w_red_wide = OUT_W'(widen(16'(w_a_rdata[2*CH_W +: CH_W]), CH_W, OUT_W));
    assign w_grn_wide = OUT_W'(widen(16'(w_a_rdata[CH_W +: CH_W]), CH_W, OUT_W));
    assign w_blu_wide = OUT_W'(widen(16'(w_a_rdata[0 +: CH_W]), CH_W, OUT_W));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vid_ok <= 1'b0;
            red      <= '0;
            green    <= '0;
            blue     <= '0;
        end else begin
            r_vid_ok <= w_run & ~blank;
            red      <= r_vid_ok ? w_red_wide : '0;
            green    <= r_vid_ok ? w_grn_wide : '0;
            blue     <= r_vid_ok ? w_blu_wide : '0;
        end
    end

endmodule
`default_nettype wire
